// File: rtl/conv_layer_stream.sv
// conv_layer_stream: streaming 1-D valid-window convolution with saturation.
// Optional: define CONV_RELU_EN to clamp negative outputs to zero.
module conv_layer_stream #(
  parameter int T = 16,
  parameter int N = 64,
  parameter int M = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic signed [T-1:0] w_data,
  input  logic                w_valid,
  output logic                w_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int AW = 2*T + $clog2(M) + 1;
  localparam int XW = $clog2(N+1);
  localparam int WW = $clog2(M+1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = (M > 1) ? $clog2(M) : 1;

  localparam logic [XW-1:0] NX = XW'(N);
  localparam logic [WW-1:0] MW = WW'(M);
  localparam logic [IW-1:0] KL = IW'(N-M);
  localparam logic [JW-1:0] JL = JW'(M-1);

  localparam logic signed [T-1:0] YMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0] YMIN = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUT
  } state_t;

  state_t state;

  logic [XW-1:0] xcnt;
  logic [WW-1:0] wcnt;
  logic [IW-1:0] k;
  logic [JW-1:0] j;
  logic [IW-1:0] idx;

  logic signed [T-1:0] xbuf [N];
  logic signed [T-1:0] wreg [M];

  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_base;
  logic signed [AW-1:0]  acc_nx;
  logic signed [2*T-1:0] prod;
  logic signed [T-1:0]   sat_v;
  logic signed [T-1:0]   y_nx;

  logic x_hs;
  logic w_hs;
  logic x_full;
  logic w_full;

  assign x_ready = (state == LOAD) && (xcnt < NX);
  assign w_ready = (state == LOAD) && (wcnt < MW);
  assign x_hs    = x_valid && x_ready;
  assign w_hs    = w_valid && w_ready;

  // Counters are full now or become full on this cycle's handshake.
  assign x_full = (xcnt == NX) || (x_hs && (xcnt == NX - XW'(1)));
  assign w_full = (wcnt == MW) || (w_hs && (wcnt == MW - WW'(1)));

  assign idx      = k + IW'(j);
  assign prod     = xbuf[idx] * wreg[j];
  assign acc_base = (j == '0) ? '0 : acc;
  assign acc_nx   = acc_base + AW'(prod);

  // Clamp the full-precision sum into the signed output range.
  always_comb begin
    sat_v = acc_nx[T-1:0];
    if (acc_nx > AW'(YMAX)) begin
      sat_v = YMAX;
    end else if (acc_nx < AW'(YMIN)) begin
      sat_v = YMIN;
    end
  end

`ifdef CONV_RELU_EN
  assign y_nx = sat_v[T-1] ? '0 : sat_v;
`else
  assign y_nx = sat_v;
`endif

  // Sample and weight storage; counters gate validity, so no reset needed.
  always_ff @(posedge clk) begin
    if (x_hs) begin
      xbuf[xcnt[IW-1:0]] <= x_data;
    end
    if (w_hs) begin
      wreg[wcnt[JW-1:0]] <= w_data;
    end
  end

  // Job sequencer: load, one MAC per cycle, hold output until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      xcnt    <= '0;
      wcnt    <= '0;
      k       <= '0;
      j       <= '0;
      acc     <= '0;
      y_data  <= '0;
      y_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state <= LOAD;
        end
        LOAD: begin
          if (x_hs) begin
            xcnt <= xcnt + XW'(1);
          end
          if (w_hs) begin
            wcnt <= wcnt + WW'(1);
          end
          if (x_full && w_full) begin
            state <= COMPUTE;
            k     <= '0;
            j     <= '0;
          end
        end
        COMPUTE: begin
          acc <= acc_nx;
          if (j == JL) begin
            state   <= OUT;
            y_data  <= y_nx;
            y_valid <= 1'b1;
          end else begin
            j <= j + JW'(1);
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            j       <= '0;
            if (k < KL) begin
              k     <= k + IW'(1);
              state <= COMPUTE;
            end else begin
              xcnt  <= '0;
              wcnt  <= '0;
              k     <= '0;
              state <= LOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
